// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : PS/2 keyboard front end. Synchronises and glitch-filters the
//               raw PS/2 clock, assembles 11-bit frames into scan codes and
//               decodes make/break/E0 sequences into ten "key held" flags
//               (player 1: W/S/A/D/Space, player 2: arrows/Enter) plus a
//               one-cycle new-press pulse.
//               Optional build macro PS2_PARITY_CHK_EN: when defined, frames
//               with even parity over data+parity are discarded; when
//               undefined the parity bit is received but ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       psClk,
    input  logic       psData,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p1_shoot,
    output logic       p2_up,
    output logic       p2_down,
    output logic       p2_left,
    output logic       p2_right,
    output logic       p2_shoot,
    output logic       press,
    output logic [7:0] scancode,
    output logic       code_valid
);

    localparam int c_filt_w = $clog2(FILTER_LEN + 1);
    localparam int c_to_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_LEN - 1);
    localparam logic [c_to_w-1:0]   c_to_limit  = c_to_w'(TIMEOUT_CYCLES);

    // Flag vector bit positions
    localparam int c_p1_up    = 0;
    localparam int c_p1_down  = 1;
    localparam int c_p1_left  = 2;
    localparam int c_p1_right = 3;
    localparam int c_p1_shoot = 4;
    localparam int c_p2_up    = 5;
    localparam int c_p2_down  = 6;
    localparam int c_p2_left  = 7;
    localparam int c_p2_right = 8;
    localparam int c_p2_shoot = 9;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

    logic                r_ps_clk_s1;
    logic                r_ps_clk_s2;
    logic                r_ps_data_s1;
    logic                r_ps_data_s2;
    logic                r_filt_clk;
    logic                r_filt_clk_d;
    logic [c_filt_w-1:0] r_filt_cnt;
    logic [3:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic [c_to_w-1:0]   r_to_cnt;
    logic [7:0]          r_scancode;
    logic                r_code_valid;
    state_t              r_state;
    state_t              w_state_next;
    logic [9:0]          r_flags;
    logic [9:0]          w_flags_next;
    logic                r_press;
    logic                w_fall;
    logic                w_frame_ok;

    // Non-extended make codes -> flag mask (keypad arrows deliberately absent)
    function automatic logic [9:0] f_map_base(input logic [7:0] code);
        logic [9:0] m;
        m = '0;
        case (code)
            8'h1D:   m[c_p1_up]    = 1'b1;
            8'h1B:   m[c_p1_down]  = 1'b1;
            8'h1C:   m[c_p1_left]  = 1'b1;
            8'h23:   m[c_p1_right] = 1'b1;
            8'h29:   m[c_p1_shoot] = 1'b1;
            8'h5A:   m[c_p2_shoot] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // E0-prefixed codes -> flag mask (keypad Enter E0 5A deliberately absent)
    function automatic logic [9:0] f_map_ext(input logic [7:0] code);
        logic [9:0] m;
        m = '0;
        case (code)
            8'h75:   m[c_p2_up]    = 1'b1;
            8'h72:   m[c_p2_down]  = 1'b1;
            8'h6B:   m[c_p2_left]  = 1'b1;
            8'h74:   m[c_p2_right] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Two-flop synchronisers for the asynchronous PS/2 lines (idle high)
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ps_clk_s1  <= 1'b1;
            r_ps_clk_s2  <= 1'b1;
            r_ps_data_s1 <= 1'b1;
            r_ps_data_s2 <= 1'b1;
        end else begin
            r_ps_clk_s1  <= psClk;
            r_ps_clk_s2  <= r_ps_clk_s1;
            r_ps_data_s1 <= psData;
            r_ps_data_s2 <= r_ps_data_s1;
        end
    end

    // Glitch filter: filtered clock follows only after FILTER_LEN differing samples
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_filt_clk   <= 1'b1;
            r_filt_clk_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_filt_clk_d <= r_filt_clk;
            if (r_ps_clk_s2 != r_filt_clk) begin
                if (r_filt_cnt == c_filt_last) begin
                    r_filt_clk <= r_ps_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_fall = r_filt_clk_d & ~r_filt_clk;

`ifdef PS2_PARITY_CHK_EN
    assign w_frame_ok = r_ps_data_s2 & (^{r_shift, r_parity});
`else
    assign w_frame_ok = r_ps_data_s2;
`endif

    // Frame receiver with inter-edge timeout; publishes a byte the cycle after the stop edge
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_scancode   <= '0;
            r_code_valid <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    // A high start bit means we are mid-stream; stay put to resync
                    if (!r_ps_data_s2) begin
                        r_bit_cnt <= 4'd1;
                    end
                end else if (r_bit_cnt <= 4'd8) begin
                    r_shift   <= {r_ps_data_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_parity  <= r_ps_data_s2;
                    r_bit_cnt <= 4'd10;
                end else begin
                    r_bit_cnt <= '0;
                    if (w_frame_ok) begin
                        r_scancode   <= r_shift;
                        r_code_valid <= 1'b1;
                    end
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == c_to_limit) begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Decode next state and next flag vector from each accepted byte
    always_comb begin
        w_state_next = r_state;
        w_flags_next = r_flags;
        if (r_code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_scancode == 8'hF0) begin
                        w_state_next = ST_BREAK;
                    end else if (r_scancode == 8'hE0) begin
                        w_state_next = ST_EXT;
                    end else begin
                        w_flags_next = r_flags | f_map_base(r_scancode);
                    end
                end
                ST_EXT: begin
                    if (r_scancode == 8'hF0) begin
                        w_state_next = ST_EXT_BREAK;
                    end else begin
                        w_flags_next = r_flags | f_map_ext(r_scancode);
                        w_state_next = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (r_scancode == 8'hF0) begin
                        w_state_next = ST_BREAK;
                    end else if (r_scancode == 8'hE0) begin
                        w_state_next = ST_EXT_BREAK;
                    end else begin
                        w_flags_next = r_flags & ~f_map_base(r_scancode);
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    if (r_scancode == 8'hF0) begin
                        w_state_next = ST_EXT_BREAK;
                    end else begin
                        w_flags_next = r_flags & ~f_map_ext(r_scancode);
                        w_state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Decode state, held flags and the rising-flag press pulse
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_flags <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_flags <= w_flags_next;
            r_press <= |(w_flags_next & ~r_flags);
        end
    end

    assign p1_up      = r_flags[c_p1_up];
    assign p1_down    = r_flags[c_p1_down];
    assign p1_left    = r_flags[c_p1_left];
    assign p1_right   = r_flags[c_p1_right];
    assign p1_shoot   = r_flags[c_p1_shoot];
    assign p2_up      = r_flags[c_p2_up];
    assign p2_down    = r_flags[c_p2_down];
    assign p2_left    = r_flags[c_p2_left];
    assign p2_right   = r_flags[c_p2_right];
    assign p2_shoot   = r_flags[c_p2_shoot];
    assign press      = r_press;
    assign scancode   = r_scancode;
    assign code_valid = r_code_valid;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Directed self-checking bench for ps2_key_decoder. Drives
//               PS/2 frames bit by bit and checks flags, scan codes and
//               pulse counts against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int TB_FILTER  = 8;
    localparam int TB_TIMEOUT = 5000;

    logic       Clk;
    logic       Reset;
    logic       psClk;
    logic       psData;
    logic       p1_up, p1_down, p1_left, p1_right, p1_shoot;
    logic       p2_up, p2_down, p2_left, p2_right, p2_shoot;
    logic       press;
    logic [7:0] scancode;
    logic       code_valid;

    wire [9:0] flags = {p2_shoot, p2_right, p2_left, p2_down, p2_up,
                        p1_shoot, p1_right, p1_left, p1_down, p1_up};

    int checks   = 0;
    int failures = 0;

    int         cv_count    = 0;
    int         press_count = 0;
    int         press_lag1  = 0;
    logic [7:0] last_code   = 8'h00;
    logic       prev_cv     = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN     (TB_FILTER),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .psClk      (psClk),
        .psData     (psData),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p1_left    (p1_left),
        .p1_right   (p1_right),
        .p1_shoot   (p1_shoot),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .p2_left    (p2_left),
        .p2_right   (p2_right),
        .p2_shoot   (p2_shoot),
        .press      (press),
        .scancode   (scancode),
        .code_valid (code_valid)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Pulse monitor sampled on the falling edge, away from the active edge
    always @(negedge Clk) begin
        if (code_valid) begin
            cv_count  <= cv_count + 1;
            last_code <= scancode;
        end
        if (press) begin
            press_count <= press_count + 1;
            if (prev_cv) press_lag1 <= press_lag1 + 1;
        end
        prev_cv <= code_valid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_bit(input logic v);
        psData = v;
        wait_cycles(15);
        psClk = 1'b0;
        wait_cycles(30);
        psClk = 1'b1;
        wait_cycles(15);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] bits;
        logic        par;
        par  = (~^b) ^ bad_par;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        psData = 1'b1;
        wait_cycles(20);
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        wait_cycles(5);
        checks++;
        if (flags !== 10'h000) begin
            failures++; $display("FAIL reset_flags: got %h expected %h", flags, 10'h000);
        end
        checks++;
        if (scancode !== 8'h00) begin
            failures++; $display("FAIL reset_scancode: got %h expected %h", scancode, 8'h00);
        end
        checks++;
        if (code_valid !== 1'b0) begin
            failures++; $display("FAIL reset_code_valid: got %b expected 0", code_valid);
        end
        checks++;
        if (press !== 1'b0) begin
            failures++; $display("FAIL reset_press: got %b expected 0", press);
        end
        Reset = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_make;
        int cv0, pr0, lag0;
        cv0 = cv_count; pr0 = press_count; lag0 = press_lag1;
        send_frame(8'h1D, 1'b0);
        checks++;
        if (cv_count - cv0 !== 1) begin
            failures++; $display("FAIL make_cv_count: got %0d expected 1", cv_count - cv0);
        end
        checks++;
        if (last_code !== 8'h1D || scancode !== 8'h1D) begin
            failures++; $display("FAIL make_scancode: got %h/%h expected 1d", last_code, scancode);
        end
        checks++;
        if (flags !== 10'h001) begin
            failures++; $display("FAIL make_flags: got %h expected %h", flags, 10'h001);
        end
        checks++;
        if (press_count - pr0 !== 1) begin
            failures++; $display("FAIL make_press_count: got %0d expected 1", press_count - pr0);
        end
        checks++;
        if (press_lag1 - lag0 !== 1) begin
            failures++; $display("FAIL make_press_timing: got %0d expected 1", press_lag1 - lag0);
        end
    endtask

    task automatic test_break;
        int cv0, pr0;
        cv0 = cv_count; pr0 = press_count;
        send_frame(8'hF0, 1'b0);
        checks++;
        if (flags !== 10'h001) begin
            failures++; $display("FAIL break_after_f0: got %h expected %h", flags, 10'h001);
        end
        send_frame(8'h1D, 1'b0);
        checks++;
        if (flags !== 10'h000) begin
            failures++; $display("FAIL break_flags: got %h expected %h", flags, 10'h000);
        end
        checks++;
        if (press_count - pr0 !== 0) begin
            failures++; $display("FAIL break_press: got %0d expected 0", press_count - pr0);
        end
        checks++;
        if (cv_count - cv0 !== 2) begin
            failures++; $display("FAIL break_cv_count: got %0d expected 2", cv_count - cv0);
        end
        // Break with no prior make leaves the flag low
        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b0);
        checks++;
        if (flags !== 10'h000 || press_count - pr0 !== 0) begin
            failures++; $display("FAIL orphan_break: got %h/%0d expected 000/0", flags, press_count - pr0);
        end
    endtask

    task automatic test_extended;
        int pr0;
        pr0 = press_count;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        checks++;
        if (flags !== 10'h020) begin
            failures++; $display("FAIL ext_make: got %h expected %h", flags, 10'h020);
        end
        send_frame(8'h75, 1'b0);
        checks++;
        if (flags !== 10'h020) begin
            failures++; $display("FAIL keypad_75: got %h expected %h", flags, 10'h020);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'h5A, 1'b0);
        checks++;
        if (flags !== 10'h020) begin
            failures++; $display("FAIL keypad_enter: got %h expected %h", flags, 10'h020);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        checks++;
        if (flags !== 10'h000) begin
            failures++; $display("FAIL ext_break: got %h expected %h", flags, 10'h000);
        end
        checks++;
        if (press_count - pr0 !== 1) begin
            failures++; $display("FAIL ext_press_count: got %0d expected 1", press_count - pr0);
        end
    endtask

    task automatic test_multi_held;
        int pr0;
        pr0 = press_count;
        send_frame(8'h29, 1'b0);
        send_frame(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) send_frame(8'h29, 1'b0);
        checks++;
        if (flags !== 10'h210) begin
            failures++; $display("FAIL multi_flags: got %h expected %h", flags, 10'h210);
        end
        checks++;
        if (press_count - pr0 !== 2) begin
            failures++; $display("FAIL multi_press_count: got %0d expected 2", press_count - pr0);
        end
    endtask

    task automatic test_timeout;
        int cv0;
        cv0 = cv_count;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        psData = 1'b1;
        wait_cycles(TB_TIMEOUT + 10);
        checks++;
        if (cv_count - cv0 !== 0) begin
            failures++; $display("FAIL timeout_partial_cv: got %0d expected 0", cv_count - cv0);
        end
        send_frame(8'h1C, 1'b0);
        checks++;
        if (cv_count - cv0 !== 1 || last_code !== 8'h1C) begin
            failures++; $display("FAIL timeout_recover: got %0d/%h expected 1/1c", cv_count - cv0, last_code);
        end
        checks++;
        if (flags !== 10'h214) begin
            failures++; $display("FAIL timeout_flags: got %h expected %h", flags, 10'h214);
        end
    endtask

    task automatic test_parity_and_reset;
        int cv0;
        cv0 = cv_count;
        send_frame(8'h1B, 1'b1);
`ifdef PS2_PARITY_CHK_EN
        checks++;
        if (cv_count - cv0 !== 0) begin
            failures++; $display("FAIL parity_cv: got %0d expected 0", cv_count - cv0);
        end
        checks++;
        if (flags !== 10'h214) begin
            failures++; $display("FAIL parity_flags: got %h expected %h", flags, 10'h214);
        end
`else
        checks++;
        if (cv_count - cv0 !== 1) begin
            failures++; $display("FAIL parity_cv: got %0d expected 1", cv_count - cv0);
        end
        checks++;
        if (flags !== 10'h216) begin
            failures++; $display("FAIL parity_flags: got %h expected %h", flags, 10'h216);
        end
`endif
        Reset = 1'b0;
        wait_cycles(1);
        Reset = 1'b1;
        wait_cycles(1);
        checks++;
        if (flags !== 10'h000) begin
            failures++; $display("FAIL reset_clears_flags: got %h expected %h", flags, 10'h000);
        end
        // A key held across reset reasserts on its next typematic make
        send_frame(8'h29, 1'b0);
        checks++;
        if (flags !== 10'h010) begin
            failures++; $display("FAIL post_reset_make: got %h expected %h", flags, 10'h010);
        end
    endtask

    initial begin
        Reset  = 1'b0;
        psClk  = 1'b1;
        psData = 1'b1;
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_multi_held();
        test_timeout();
        test_parity_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Front-end input stage feeding the game top level: receives raw PS/2 clock/data from the keyboard and assembles 11-bit frames into scan codes.
- Tracks make/break and E0-extended prefixes.
- Drives ten level "key held" flags (P1: W/S/A/D/Space; P2: arrow keys/Enter) plus a new-press pulse; the player blocks consume these flags on the frame clock.

Parameters:
- FILTER_LEN, 8: consecutive identical Clk samples required before filtered psClk changes level.
- TIMEOUT_CYCLES, 5000: Clk cycles allowed between filtered psClk falling edges inside a frame before the partial frame is discarded (100 us at 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz; sole clock domain.
- Reset  in  1  synchronous, active-low reset.
- psClk  in  1  raw PS/2 clock, asynchronous.
- psData  in  1  raw PS/2 data, asynchronous.
- p1_up, p1_down, p1_left, p1_right, p1_shoot  out  1 each  held flags for W(1D), S(1B), A(1C), D(23), Space(29).
- p2_up, p2_down, p2_left, p2_right  out  1 each  held flags for E0 75, E0 72, E0 6B, E0 74.
- p2_shoot  out  1  held flag for Enter(5A).
- press  out  1  one-cycle pulse when any mapped flag goes 0->1.
- scancode  out  8  last accepted data byte.
- code_valid  out  1  one-cycle pulse when scancode updates.

Behaviour:
- Reset (Reset==0 at a Clk edge): all outputs 0, decode FSM in IDLE, bit counter 0, shift register 0, filters load 1.
- Synchronisation: psClk and psData each pass through 2 flops. Filtered psClk toggles only after FILTER_LEN equal samples that differ from its current value.
- Falling-edge event: filtered psClk goes 1->0. psData (synchronised) is sampled in that same cycle.
- Frame receive: bit counter 0..10.
  - Edge 0: start bit. If data==1, ignore the edge and keep the counter at 0 (resync).
  - Edges 1-8: data bits, LSB first.
  - Edge 9: parity.
  - Edge 10: stop bit.
  - On edge 10: accept if stop==1 and odd parity holds over data+parity; otherwise discard. The counter returns to 0 in either case.
- Timeout: a counter clears on each falling edge. If the bit counter is nonzero and the counter reaches TIMEOUT_CYCLES, the bit counter returns to 0 and the partial frame is discarded with no output.
- Accept timing:
  - scancode and code_valid are registered 1 cycle after the edge-10 cycle.
  - Flags and press update on the cycle after code_valid, i.e. 2 cycles after edge 10.
- Decode FSM states: IDLE, BREAK, EXT, EXT_BREAK, evaluated on each code_valid.
  - IDLE: F0 -> BREAK; E0 -> EXT; otherwise look up a non-extended make, set the flag, stay IDLE.
  - EXT: F0 -> EXT_BREAK; otherwise look up an extended make -> IDLE.
  - BREAK: clear the matching non-extended flag -> IDLE.
  - EXT_BREAK: clear the matching extended flag -> IDLE.
  - Repeated F0 in BREAK/EXT_BREAK: stay. E0 in BREAK: go to EXT_BREAK.
- Lookup rules:
  - Unmapped codes, including E1 pause bytes, cause no flag change but still return the FSM to IDLE.
  - Non-extended 75/72/6B/74 (keypad) are unmapped.
  - Extended 5A (keypad Enter) is unmapped.
- Typematic repeats (make while already held): flag stays 1, no press pulse.
- Break without a prior make: flag stays 0, no pulse.
- Multiple keys held at once are independent; no priority between flags.
- Reset mid-frame: the frame is abandoned, and flags clear even if keys are physically held. A key held across reset reasserts on its next typematic make.

Optional Feature:
- Macro: PS2_PARITY_CHK_EN.
- Defined: frames with even parity over data+parity are discarded (no code_valid, FSM unchanged).
- Undefined: the parity bit is received but ignored; acceptance depends only on a valid start bit and stop==1.
- Timing is identical in both builds.

Test Plan:
- Send frame 1D (odd parity, stop 1) -> code_valid pulse, scancode=0x1D; p1_up=1 and press pulse 2 cycles after edge 10; all other flags 0.
- Send 1D, then F0 1D -> p1_up returns 0 after the second 1D; no press pulse on the break.
- Send E0 75, then 75 alone, then E0 F0 75 -> p2_up=1 after E0 75; the lone 75 is keypad, so no change; p2_up=0 after E0 F0 75.
- Hold 29 and 5A (both makes), repeat 29 three times -> p1_shoot=1 and p2_shoot=1, exactly two press pulses total.
- Send 5 bits of a frame, stall psClk for TIMEOUT_CYCLES+10, then a full 1C frame -> no output for the partial frame; p1_left=1 after the full one.
- Send 1B with a wrong parity bit -> with PS2_PARITY_CHK_EN: no code_valid, p1_down=0. Without it: p1_down=1. Then assert Reset for 1 cycle -> all flags 0.
